// File: rtl/interrupt_enable_dispatch.sv
// Interrupt enable register, IME master flag with delayed EI, and vectored dispatch FSM.
module interrupt_enable_dispatch #(
    parameter int unsigned NUM_IRQ    = 5,
    parameter logic [7:0]  VEC_BASE   = 8'h40,
    parameter int unsigned VEC_STRIDE = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [7:0]         DL,
    input  logic               ie_load,
    output logic [7:0]         ie_dout,
    input  logic [NUM_IRQ-1:0] irq_if,
    input  logic               instr_end,
    input  logic               op_ei,
    input  logic               op_di,
    input  logic               op_reti,
    input  logic               int_ack,
    input  logic               vec_sample,
    output logic               int_req,
    output logic [7:0]         int_vector,
    output logic [NUM_IRQ-1:0] if_clear,
    output logic               ime,
    output logic               halt_wake
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DISP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         ie_reg;
    logic               ei_pend;
    logic [NUM_IRQ-1:0] pend;
    logic [7:0]         sel_vec;
    logic [NUM_IRQ-1:0] sel_clr;

    assign ie_dout   = ie_reg;
    assign pend      = ie_reg[NUM_IRQ-1:0] & irq_if;
    assign halt_wake = |pend;
    assign int_req   = (state == REQ);

    // IE register: written from the data latch bus on the IE write strobe
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ie_reg <= 8'h00;
        end else if (ie_load) begin
            ie_reg <= DL;
        end
    end

    // IME master flag; EI takes effect only at the instruction boundary after it
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ime     <= 1'b0;
            ei_pend <= 1'b0;
        end else if (int_ack) begin
            ime     <= 1'b0;
            ei_pend <= 1'b0;
        end else if (op_di) begin
            ime     <= 1'b0;
            ei_pend <= 1'b0;
        end else if (op_reti) begin
            ime     <= 1'b1;
        end else if (op_ei) begin
            ei_pend <= 1'b1;
        end else if (ei_pend && instr_end) begin
            ime     <= 1'b1;
            ei_pend <= 1'b0;
        end
    end

    // Lowest-index pending request wins; no request yields vector 00 and no clear
    always_comb begin
        sel_vec = 8'h00;
        sel_clr = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_vec = VEC_BASE + 8'(32'(i) * VEC_STRIDE);
                sel_clr = NUM_IRQ'(1) << i;
            end
        end
    end

    // Dispatch FSM state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dispatch FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ime && (|pend) && instr_end) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_nxt = DISP;
                end else if (!ime || op_di) begin
                    state_nxt = IDLE;
                end
            end
            DISP: begin
                if (vec_sample) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Vector and IF-clear pulse, sampled from pend at the vector-fetch point
    always_ff @(posedge CLK) begin
        if (RESET) begin
            int_vector <= 8'h00;
            if_clear   <= '0;
        end else begin
            if_clear <= '0;
            if (state == DISP && vec_sample) begin
                int_vector <= sel_vec;
                if_clear   <= sel_clr;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_enable_dispatch.sv
// Directed bench for interrupt_enable_dispatch with a dispatch-result scoreboard.
module tb_interrupt_enable_dispatch;

    typedef struct packed {
        logic [7:0] vec;
        logic [4:0] clr;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] DL;
    logic       ie_load;
    logic [7:0] ie_dout;
    logic [4:0] irq_if;
    logic       instr_end;
    logic       op_ei;
    logic       op_di;
    logic       op_reti;
    logic       int_ack;
    logic       vec_sample;
    logic       int_req;
    logic [7:0] int_vector;
    logic [4:0] if_clear;
    logic       ime;
    logic       halt_wake;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    interrupt_enable_dispatch dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .DL         (DL),
        .ie_load    (ie_load),
        .ie_dout    (ie_dout),
        .irq_if     (irq_if),
        .instr_end  (instr_end),
        .op_ei      (op_ei),
        .op_di      (op_di),
        .op_reti    (op_reti),
        .int_ack    (int_ack),
        .vec_sample (vec_sample),
        .int_req    (int_req),
        .int_vector (int_vector),
        .if_clear   (if_clear),
        .ime        (ime),
        .halt_wake  (halt_wake)
    );

    always #5 CLK = ~CLK;

    // Advance one clock, then release all single-cycle pulses
    task automatic tick();
        @(posedge CLK);
        #1;
        ie_load    = 1'b0;
        instr_end  = 1'b0;
        op_ei      = 1'b0;
        op_di      = 1'b0;
        op_reti    = 1'b0;
        int_ack    = 1'b0;
        vec_sample = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Pop the expected dispatch result and compare against the registered outputs
    task automatic sb_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_vec"}, int_vector, e.vec);
            chk({tag, "_clr"}, 8'(if_clear), 8'(e.clr));
        end
    endtask

    initial begin
        RESET = 1'b1; DL = 8'h00; ie_load = 1'b0; irq_if = 5'b0; instr_end = 1'b0;
        op_ei = 1'b0; op_di = 1'b0; op_reti = 1'b0; int_ack = 1'b0; vec_sample = 1'b0;

        // 1: reset state
        tick(); tick();
        chk("rst_ie",   ie_dout, 8'h00);
        chk("rst_ime",  8'(ime), 8'd0);
        chk("rst_req",  8'(int_req), 8'd0);
        chk("rst_vec",  int_vector, 8'h00);
        chk("rst_clr",  8'(if_clear), 8'h00);
        chk("rst_wake", 8'(halt_wake), 8'd0);
        RESET = 1'b0;

        // 2: load IE, EI delayed by one boundary, full dispatch of request 2
        DL = 8'h1F; ie_load = 1'b1; irq_if = 5'b00100; op_ei = 1'b1;
        tick();
        chk("t2_ie",   ie_dout, 8'h1F);
        chk("t2_ime0", 8'(ime), 8'd0);
        chk("t2_wake", 8'(halt_wake), 8'd1);
        instr_end = 1'b1; tick();
        chk("t2_ime1", 8'(ime), 8'd1);
        chk("t2_req0", 8'(int_req), 8'd0);
        instr_end = 1'b1; tick();
        chk("t2_req1", 8'(int_req), 8'd1);
        int_ack = 1'b1; tick();
        chk("t2_ack_ime", 8'(ime), 8'd0);
        chk("t2_ack_req", 8'(int_req), 8'd0);
        vec_sample = 1'b1; sb.push_back('{vec: 8'h50, clr: 5'b00100});
        tick();
        sb_check("t2_disp");
        tick();
        chk("t2_clr_pulse", 8'(if_clear), 8'h00);
        chk("t2_vec_hold",  int_vector, 8'h50);

        // 3: several pending, lowest index wins
        irq_if = 5'b10110; op_reti = 1'b1; tick();
        chk("t3_ime", 8'(ime), 8'd1);
        instr_end = 1'b1; tick();
        chk("t3_req", 8'(int_req), 8'd1);
        int_ack = 1'b1; tick();
        vec_sample = 1'b1; sb.push_back('{vec: 8'h48, clr: 5'b00010});
        tick();
        sb_check("t3_disp");

        // 4: instr_end coinciding with EI does not promote; DI aborts a request
        op_ei = 1'b1; instr_end = 1'b1; tick();
        chk("t4_same", 8'(ime), 8'd0);
        tick();
        chk("t4_wait", 8'(ime), 8'd0);
        instr_end = 1'b1; tick();
        chk("t4_ime", 8'(ime), 8'd1);
        chk("t4_req", 8'(int_req), 8'd0);
        instr_end = 1'b1; tick();
        chk("t4_req1", 8'(int_req), 8'd1);
        op_di = 1'b1; tick();
        chk("t4_di_ime", 8'(ime), 8'd0);
        chk("t4_di_req", 8'(int_req), 8'd0);

        // 5: IE cleared mid-dispatch gives null vector and no clear
        op_reti = 1'b1; tick();
        instr_end = 1'b1; tick();
        int_ack = 1'b1; tick();
        DL = 8'h00; ie_load = 1'b1; tick();
        chk("t5_ie",   ie_dout, 8'h00);
        chk("t5_wake", 8'(halt_wake), 8'd0);
        vec_sample = 1'b1; sb.push_back('{vec: 8'h00, clr: 5'b00000});
        tick();
        sb_check("t5_disp");
        chk("t5_idle", 8'(int_req), 8'd0);

        // 6: wake independent of IME; RETI re-enables
        DL = 8'h04; ie_load = 1'b1; irq_if = 5'b00100; tick();
        instr_end = 1'b1; tick();
        chk("t6_wake", 8'(halt_wake), 8'd1);
        chk("t6_noreq", 8'(int_req), 8'd0);
        op_reti = 1'b1; tick();
        chk("t6_reti_req", 8'(int_req), 8'd0);
        instr_end = 1'b1; tick();
        chk("t6_req", 8'(int_req), 8'd1);
        int_ack = 1'b1; tick();
        // IE write alongside vec_sample: old IE is used
        DL = 8'h00; ie_load = 1'b1; vec_sample = 1'b1;
        sb.push_back('{vec: 8'h50, clr: 5'b00100});
        tick();
        sb_check("t6_old_ie");
        chk("t6_new_ie", ie_dout, 8'h00);

        // Reset in the middle of a dispatch
        DL = 8'h04; ie_load = 1'b1; op_reti = 1'b1; tick();
        instr_end = 1'b1; tick();
        int_ack = 1'b1; tick();
        RESET = 1'b1; vec_sample = 1'b1; tick();
        chk("mr_clr", 8'(if_clear), 8'h00);
        chk("mr_vec", int_vector, 8'h00);
        chk("mr_req", 8'(int_req), 8'd0);
        chk("mr_ie",  ie_dout, 8'h00);
        RESET = 1'b0; tick();
        chk("mr_ime", 8'(ime), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
